// File: rtl/dsky_serial_frame_decoder.sv
// Parses 5-byte [SYNC][ID][HI][LO][CK] frames from the UART byte stream.
// It holds the six 15-bit input registers that the AGC core reads through the IO unit.
module dsky_serial_frame_decoder #(
    parameter int          NUM_REGS       = 6,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [14:0] DSKY_VERB_data,
    output logic [14:0] DSKY_NOUN_data,
    output logic [14:0] AXI_G_data,
    output logic [14:0] AXI_RA_data,
    output logic [14:0] AXI_RB_data,
    output logic [14:0] AXI_ATX_data,
    output logic        update_pulse,
    output logic [2:0]  update_id,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    NUM_REGS_B   = 8'(NUM_REGS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ID,
        GET_HI,
        GET_LO,
        GET_CK
    } state_t;

    state_t        state;
    logic [7:0]    id_q;
    logic [7:0]    hi_q;
    logic [7:0]    lo_q;
    logic [TW-1:0] timeout_cnt;

    // Bytes advance the FSM; a stall that runs the gap counter out abandons
    // the frame. Rejections from any state funnel through one local flag so
    // the error pulse and saturating count are updated in a single place.
    always_ff @(posedge clock or negedge reset_n) begin
        logic reject;
        if (!reset_n) begin
            state          <= IDLE;
            id_q           <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            timeout_cnt    <= '0;
            DSKY_VERB_data <= '0;
            DSKY_NOUN_data <= '0;
            AXI_G_data     <= '0;
            AXI_RA_data    <= '0;
            AXI_RB_data    <= '0;
            AXI_ATX_data   <= '0;
            update_pulse   <= 1'b0;
            update_id      <= '0;
            frame_err      <= 1'b0;
            err_count      <= '0;
        end else begin
            reject       = 1'b0;
            update_pulse <= 1'b0;
            frame_err    <= 1'b0;

            if (rx_valid) begin
                timeout_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE)
                            state <= GET_ID;
                    end
                    GET_ID: begin
                        id_q <= rx_data;
                        if (rx_data >= NUM_REGS_B) begin
                            reject = 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= GET_HI;
                        end
                    end
                    GET_HI: begin
                        hi_q <= rx_data;
                        if (rx_data[7]) begin
                            reject = 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= GET_LO;
                        end
                    end
                    GET_LO: begin
                        lo_q  <= rx_data;
                        state <= GET_CK;
                    end
                    GET_CK: begin
                        state <= IDLE;
                        if (rx_data == (id_q ^ hi_q ^ lo_q)) begin
                            update_pulse <= 1'b1;
                            update_id    <= id_q[2:0];
                            case (id_q[2:0])
                                3'd0:    DSKY_VERB_data <= {hi_q[6:0], lo_q};
                                3'd1:    DSKY_NOUN_data <= {hi_q[6:0], lo_q};
                                3'd2:    AXI_G_data     <= {hi_q[6:0], lo_q};
                                3'd3:    AXI_RA_data    <= {hi_q[6:0], lo_q};
                                3'd4:    AXI_RB_data    <= {hi_q[6:0], lo_q};
                                3'd5:    AXI_ATX_data   <= {hi_q[6:0], lo_q};
                                default: ;
                            endcase
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (timeout_cnt == TIMEOUT_LAST) begin
                    reject      = 1'b1;
                    state       <= IDLE;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end

            if (reject) begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsky_serial_frame_decoder.sv
// Directed bench for dsky_serial_frame_decoder: a byte-queue frame model is
// compared against the DUT every cycle, with literal checks on key results.
module tb_dsky_serial_frame_decoder;

    localparam int TIMEOUT = 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [14:0] DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data;
    logic [14:0] AXI_RA_data, AXI_RB_data, AXI_ATX_data;
    logic        update_pulse, frame_err;
    logic [2:0]  update_id;
    logic [7:0]  err_count;

    int tests_run = 0;
    int tests_failed = 0;

    dsky_serial_frame_decoder #(
        .NUM_REGS(6),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .DSKY_VERB_data(DSKY_VERB_data),
        .DSKY_NOUN_data(DSKY_NOUN_data),
        .AXI_G_data(AXI_G_data),
        .AXI_RA_data(AXI_RA_data),
        .AXI_RB_data(AXI_RB_data),
        .AXI_ATX_data(AXI_ATX_data),
        .update_pulse(update_pulse),
        .update_id(update_id),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Model: collect bytes of the current frame in a queue and judge the
    // frame by how many bytes it holds; a gap count abandons stalled frames.
    logic [7:0]  frame_buf[$];
    int          gap;
    logic [14:0] exp_regs[6];
    logic        exp_pulse, exp_err;
    logic [2:0]  exp_id;
    int          exp_cnt;

    task automatic model_reject();
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
        frame_buf.delete();
        gap = 0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_buf.delete();
            gap = 0;
            foreach (exp_regs[i]) exp_regs[i] = '0;
            exp_pulse = 1'b0;
            exp_err = 1'b0;
            exp_id = '0;
            exp_cnt = 0;
        end else begin
            exp_pulse = 1'b0;
            exp_err = 1'b0;
            if (rx_valid) begin
                gap = 0;
                if (frame_buf.size() != 0 || rx_data == 8'hA5)
                    frame_buf.push_back(rx_data);
                if (frame_buf.size() == 2 && frame_buf[1] >= 6) begin
                    model_reject();
                end else if (frame_buf.size() == 3 && frame_buf[2] >= 8'h80) begin
                    model_reject();
                end else if (frame_buf.size() == 5) begin
                    if (frame_buf[4] == (frame_buf[1] ^ frame_buf[2] ^ frame_buf[3])) begin
                        exp_regs[frame_buf[1]] = {frame_buf[2][6:0], frame_buf[3]};
                        exp_pulse = 1'b1;
                        exp_id = frame_buf[1][2:0];
                        frame_buf.delete();
                    end else begin
                        model_reject();
                    end
                end
            end else if (frame_buf.size() != 0) begin
                gap++;
                if (gap == TIMEOUT) model_reject();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    bit check_en = 1'b0;

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (check_en && reset_n) begin
            checkOutput("verb", 32'(DSKY_VERB_data), 32'(exp_regs[0]));
            checkOutput("noun", 32'(DSKY_NOUN_data), 32'(exp_regs[1]));
            checkOutput("g",    32'(AXI_G_data),     32'(exp_regs[2]));
            checkOutput("ra",   32'(AXI_RA_data),    32'(exp_regs[3]));
            checkOutput("rb",   32'(AXI_RB_data),    32'(exp_regs[4]));
            checkOutput("atx",  32'(AXI_ATX_data),   32'(exp_regs[5]));
            checkOutput("update_pulse", 32'(update_pulse), 32'(exp_pulse));
            if (exp_pulse) checkOutput("update_id", 32'(update_id), 32'(exp_id));
            checkOutput("frame_err", 32'(frame_err), 32'(exp_err));
            checkOutput("err_count", 32'(err_count), 32'(exp_cnt));
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data = b;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] e);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
        applyStimulus(e);
    endtask

    initial begin
        reset_n = 1'b0;
        #23;
        reset_n = 1'b1;
        check_en = 1'b1;
        idleCycles(2);
        checkOutput("reset err_count", 32'(err_count), 32'h0);
        checkOutput("reset verb", 32'(DSKY_VERB_data), 32'h0);

        // Good verb and ATX frames.
        sendFrame(8'hA5, 8'h00, 8'h00, 8'h37, 8'h37);
        idleCycles(1);
        checkOutput("verb value", 32'(DSKY_VERB_data), 32'h0037);
        checkOutput("verb pulse", 32'(update_pulse), 32'h1);
        checkOutput("verb id", 32'(update_id), 32'h0);
        sendFrame(8'hA5, 8'h05, 8'h0A, 8'hBC, 8'hB3);
        idleCycles(1);
        checkOutput("atx value", 32'(AXI_ATX_data), 32'h0ABC);
        checkOutput("atx id", 32'(update_id), 32'h5);

        // Rejected frames: bad checksum, bad ID, HI bit7 set.
        sendFrame(8'hA5, 8'h02, 8'h01, 8'h23, 8'h00);
        idleCycles(1);
        checkOutput("badck g", 32'(AXI_G_data), 32'h0);
        checkOutput("badck err", 32'(frame_err), 32'h1);
        checkOutput("badck count", 32'(err_count), 32'h1);
        applyStimulus(8'hA5);
        applyStimulus(8'h07);
        idleCycles(1);
        checkOutput("badid count", 32'(err_count), 32'h2);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h81);
        idleCycles(1);
        checkOutput("badhi count", 32'(err_count), 32'h3);
        idleCycles(2);

        // Timeout after a full stall, then a frame with a stall one short of it.
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        idleCycles(TIMEOUT);
        @(negedge clock);
        checkOutput("timeout err", 32'(frame_err), 32'h1);
        checkOutput("timeout count", 32'(err_count), 32'h4);
        applyStimulus(8'hA5);
        applyStimulus(8'h03);
        applyStimulus(8'h07);
        idleCycles(TIMEOUT - 1);
        applyStimulus(8'h89);
        applyStimulus(8'h8D);
        idleCycles(1);
        checkOutput("ra value", 32'(AXI_RA_data), 32'h0789);
        checkOutput("ra count", 32'(err_count), 32'h4);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        @(posedge clock);
        #2;
        rx_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("async verb", 32'(DSKY_VERB_data), 32'h0);
        checkOutput("async ra", 32'(AXI_RA_data), 32'h0);
        checkOutput("async atx", 32'(AXI_ATX_data), 32'h0);
        checkOutput("async count", 32'(err_count), 32'h0);
        #1;
        reset_n = 1'b1;
        applyStimulus(8'h05);
        sendFrame(8'hA5, 8'h01, 8'h00, 8'h05, 8'h04);
        idleCycles(1);
        checkOutput("noun value", 32'(DSKY_NOUN_data), 32'h0005);
        checkOutput("noun count", 32'(err_count), 32'h0);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++)
            sendFrame(8'hA5, 8'h02, 8'h01, 8'h23, 8'h00);
        idleCycles(1);
        checkOutput("saturate", 32'(err_count), 32'hFF);

        // Back-to-back frames with rx_valid held high throughout.
        sendFrame(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26);
        sendFrame(8'hA5, 8'h04, 8'h7F, 8'hFF, 8'h84);
        idleCycles(1);
        checkOutput("stream rb", 32'(AXI_RB_data), 32'h7FFF);
        checkOutput("stream verb", 32'(DSKY_VERB_data), 32'h1234);
        checkOutput("stream count", 32'(err_count), 32'hFF);
        idleCycles(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
